snake_score_tracker: RTL and testbench

- Parametrised successor to the snake score counter.
- Compares the snake head against N_FOOD food slots and counts exactly one score event per eaten food.
- Reports which slot was eaten to the food-respawn logic through a valid/ack handshake.
- Tracks game phase (idle/play/over), a session high score and a difficulty level for the speed controller.

---
 rtl/snake_pkg.sv | 14 +
 rtl/food_hit_detect.sv | 33 +++
 rtl/snake_score_tracker.sv | 123 ++++++++++++
 tb/tb_snake_score_tracker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks.
package snake_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;

  localparam int DEF_X_W  = 10;
  localparam int DEF_Y_W  = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Index width that stays legal for a single-slot configuration.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/food_hit_detect.sv
// Compares the head against every food slot; reports any hit and the lowest matching slot.
module food_hit_detect
  import snake_pkg::*;
#(
  parameter int N_FOOD = 9,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int IDX_W  = idx_w(N_FOOD)
) (
  input  logic [X_W-1:0]    headx,
  input  logic [Y_W-1:0]    heady,
  input  logic [X_W-1:0]    foodx [N_FOOD],
  input  logic [Y_W-1:0]    foody [N_FOOD],
  input  logic [N_FOOD-1:0] food_valid,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
);
  logic [N_FOOD-1:0] w_match;

  for (genvar g = 0; g < N_FOOD; g++) begin : g_slot
    assign w_match[g] = food_valid[g] && (foodx[g] == headx) && (foody[g] == heady);
  end

  assign hit = |w_match;

  // Scan downward so the lowest matching slot is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int i = N_FOOD - 1; i >= 0; i--) begin
      if (w_match[i]) hit_idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/snake_score_tracker.sv
// Game phase FSM, saturating score, session high score, level and eat-event handshake.
module snake_score_tracker
  import snake_pkg::*;
#(
  parameter int N_FOOD     = 9,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int SCORE_W    = 8,
  parameter int INIT_SCORE = 2,
  parameter int POINTS     = 1,
  parameter int LEVEL_STEP = 5,
  parameter int LEVEL_W    = 3,
  parameter int IDX_W      = idx_w(N_FOOD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               game_over,
  input  logic [X_W-1:0]     headx,
  input  logic [Y_W-1:0]     heady,
  input  logic [X_W-1:0]     foodx [N_FOOD],
  input  logic [Y_W-1:0]     foody [N_FOOD],
  input  logic [N_FOOD-1:0]  food_valid,
  output logic               eat_valid,
  output logic [IDX_W-1:0]   eat_idx,
  input  logic               eat_ack,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [LEVEL_W-1:0] level,
  output logic               playing
);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_INIT = SCORE_W'(INIT_SCORE);
  localparam logic [SCORE_W-1:0] LEVEL_CAP = SCORE_W'((1 << LEVEL_W) - 1);

  game_state_t r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_score, r_high;
  logic [LEVEL_W-1:0] r_level;
  logic               r_eat_valid;
  logic [IDX_W-1:0]   r_eat_idx;

  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_start_go, w_over_go, w_eat;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_score_sat, w_above, w_quot;
  logic [LEVEL_W-1:0] w_level_nxt;

  food_hit_detect #(
    .N_FOOD(N_FOOD), .X_W(X_W), .Y_W(Y_W), .IDX_W(IDX_W)
  ) u_hit (
    .headx(headx), .heady(heady), .foodx(foodx), .foody(foody),
    .food_valid(food_valid), .hit(w_hit), .hit_idx(w_hit_idx)
  );

  // Saturating add: widen by one bit so overflow is visible before clamping.
  assign w_sum       = {1'b0, r_score} + (SCORE_W + 1)'(POINTS);
  assign w_score_sat = (w_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_sum[SCORE_W-1:0];

  // Constant divisor, so this folds into fixed logic rather than a divider.
  assign w_above     = (r_score > SCORE_INIT) ? (r_score - SCORE_INIT) : '0;
  assign w_quot      = w_above / SCORE_W'(LEVEL_STEP);
  assign w_level_nxt = (w_quot > LEVEL_CAP) ? LEVEL_CAP[LEVEL_W-1:0] : w_quot[LEVEL_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_start_go  = 1'b0;
    w_over_go   = 1'b0;
    w_eat       = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_state_nxt = PLAY;
          w_start_go  = 1'b1;
        end
      end
      PLAY: begin
        if (game_over) begin
          w_state_nxt = OVER;
          w_over_go   = 1'b1;
        end else if (w_hit && !r_eat_valid) begin
          w_eat = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_score     <= SCORE_INIT;
      r_high      <= '0;
      r_level     <= '0;
      r_eat_valid <= 1'b0;
      r_eat_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      if (w_start_go) begin
        r_score     <= SCORE_INIT;
        r_level     <= '0;
        r_eat_valid <= 1'b0;
      end else if (w_over_go) begin
        r_high      <= (r_score > r_high) ? r_score : r_high;
        r_eat_valid <= 1'b0;
      end else if (w_eat) begin
        r_score     <= w_score_sat;
        r_eat_valid <= 1'b1;
        r_eat_idx   <= w_hit_idx;
      end else if (r_state == PLAY && r_eat_valid && eat_ack) begin
        r_eat_valid <= 1'b0;
      end
    end
  end

  assign eat_valid  = r_eat_valid;
  assign eat_idx    = r_eat_idx;
  assign score      = r_score;
  assign high_score = r_high;
  assign level      = r_level;
  assign playing    = (r_state == PLAY);
endmodule

// File: tb/tb_snake_score_tracker.sv
// Directed bench for snake_score_tracker with hand-computed expectations.
module tb_snake_score_tracker;
  localparam int N_FOOD = 9;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  logic             clk = 1'b0;
  logic             reset, start, game_over, eat_ack;
  logic [X_W-1:0]   headx;
  logic [Y_W-1:0]   heady;
  logic [X_W-1:0]   foodx [N_FOOD];
  logic [Y_W-1:0]   foody [N_FOOD];
  logic [N_FOOD-1:0] food_valid;
  logic             eat_valid, playing;
  logic [3:0]       eat_idx;
  logic [7:0]       score, high_score;
  logic [2:0]       level;

  int checks = 0;
  int failures = 0;

  snake_score_tracker dut (
    .clk(clk), .reset(reset), .start(start), .game_over(game_over),
    .headx(headx), .heady(heady), .foodx(foodx), .foody(foody),
    .food_valid(food_valid), .eat_valid(eat_valid), .eat_idx(eat_idx),
    .eat_ack(eat_ack), .score(score), .high_score(high_score),
    .level(level), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One eat on slot 0 (parked at the head) followed by its ack cycle.
  task automatic eat0();
    food_valid[0] = 1'b1;
    step();
    eat_ack = 1'b1;
    food_valid[0] = 1'b0;
    step();
    eat_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; game_over = 1'b0; eat_ack = 1'b0;
    headx = 10'd100; heady = 9'd50; food_valid = '0;
    for (int i = 0; i < N_FOOD; i++) begin
      foodx[i] = 10'(i * 7);
      foody[i] = 9'(i * 3);
    end
    foodx[0] = 10'd100; foody[0] = 9'd50;
    #12;
    chk("rst_score", score, 2);
    chk("rst_high", high_score, 0);
    chk("rst_level", level, 0);
    chk("rst_eat_valid", eat_valid, 0);
    chk("rst_eat_idx", eat_idx, 0);
    chk("rst_playing", playing, 0);
    reset = 1'b1;

    // Food under the head while idle must not score.
    foodx[3] = 10'd100; foody[3] = 9'd50; food_valid[3] = 1'b1;
    step();
    chk("idle_hit_score", score, 2);
    chk("idle_hit_valid", eat_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_playing", playing, 1);
    chk("start_score", score, 2);
    step();
    chk("t1_score", score, 3);
    chk("t1_valid", eat_valid, 1);
    chk("t1_idx", eat_idx, 3);
    repeat (10) step();
    chk("t1_park_score", score, 3);
    chk("t1_park_valid", eat_valid, 1);
    chk("t1_park_idx", eat_idx, 3);

    eat_ack = 1'b1; food_valid[3] = 1'b0;
    step();
    eat_ack = 1'b0;
    chk("t2_ack_valid", eat_valid, 0);
    chk("t2_ack_score", score, 3);
    food_valid[0] = 1'b1;
    step();
    chk("t2_score", score, 4);
    chk("t2_idx", eat_idx, 0);
    chk("t2_valid", eat_valid, 1);
    eat_ack = 1'b1; food_valid[0] = 1'b0;
    step();
    chk("t2_clear", eat_valid, 0);
    step();
    eat_ack = 1'b0;
    chk("idle_ack_valid", eat_valid, 0);
    chk("idle_ack_score", score, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_play_score", score, 4);
    chk("start_in_play_playing", playing, 1);

    foodx[2] = 10'd100; foody[2] = 9'd50;
    foodx[7] = 10'd100; foody[7] = 9'd50;
    food_valid[2] = 1'b1; food_valid[7] = 1'b1;
    step();
    chk("t3_score", score, 5);
    chk("t3_idx", eat_idx, 2);
    eat_ack = 1'b1; food_valid[2] = 1'b0; food_valid[7] = 1'b0;
    step();
    eat_ack = 1'b0;
    chk("t3_single", score, 5);

    repeat (4) eat0();
    chk("t5_pre_score", score, 9);
    chk("t5_pre_level", level, 1);
    food_valid[0] = 1'b1; game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("t5_over_score", score, 9);
    chk("t5_over_playing", playing, 0);
    chk("t5_over_high", high_score, 9);
    chk("t5_over_valid", eat_valid, 0);
    step();
    chk("t5_over_hit_score", score, 9);
    chk("t5_over_hit_valid", eat_valid, 0);
    chk("t5_over_level", level, 1);
    food_valid[0] = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart_score", score, 2);
    chk("t5_restart_high", high_score, 9);
    chk("t5_restart_level", level, 0);
    chk("t5_restart_playing", playing, 1);

    repeat (9) eat0();
    food_valid[0] = 1'b1;
    step();
    chk("t6_score12", score, 12);
    chk("t6_level_lag", level, 1);
    eat_ack = 1'b1; food_valid[0] = 1'b0;
    step();
    eat_ack = 1'b0;
    chk("t6_level2", level, 2);

    repeat (243) eat0();
    chk("t4_score255", score, 255);
    chk("t4_level_cap", level, 7);
    food_valid[0] = 1'b1;
    step();
    chk("t4_sat_valid", eat_valid, 1);
    chk("t4_sat_score", score, 255);
    chk("t4_high_kept", high_score, 9);

    #2;
    reset = 1'b0;
    #1;
    chk("midrst_score", score, 2);
    chk("midrst_high", high_score, 0);
    chk("midrst_level", level, 0);
    chk("midrst_valid", eat_valid, 0);
    chk("midrst_idx", eat_idx, 0);
    chk("midrst_playing", playing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
